// File: rtl/pcie_pkg.sv
// rtl/pcie_pkg.sv - shared transaction-layer types, widths and the round-robin pick helper
package pcie_pkg;

  localparam int PIPE_DATA_WIDTH = 256;
  localparam int TX_CRED_W       = 8;

  typedef enum logic [1:0] {
    REQ_RD  = 2'd0,
    REQ_WR  = 2'd1,
    REQ_CPL = 2'd2
  } tx_req_e;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } tx_arb_state_t;

  // One-hot pick of the first set bit of elig at or after ptr, wrapping RD->WR->CPL->RD.
  function automatic logic [2:0] rr_pick(input logic [2:0] elig, input tx_req_e ptr);
    logic [2:0] pick;
    logic [1:0] idx;
    pick = '0;
    for (int k = 2; k >= 0; k--) begin
      idx = 2'((int'(ptr) + k) % 3);
      if (elig[idx]) pick = 3'b001 << idx;
    end
    return pick;
  endfunction

endpackage

// File: rtl/tlp_credit_cnt.sv
// rtl/tlp_credit_cnt.sv - saturating header-credit counter, consume and return in one cycle cancel
module tlp_credit_cnt #(
  parameter int INIT = 32,
  parameter int W    = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         consume,
  input  logic         ret,
  output logic [W-1:0] count,
  output logic         nonzero
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= W'(INIT);
    end else begin
      case ({consume, ret})
        2'b10:   r_count <= r_count - 1'b1;
        2'b01:   if (r_count != '1) r_count <= r_count + 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign count   = r_count;
  assign nonzero = (r_count != '0);

endmodule

// File: rtl/tlp_tx_arb.sv
// rtl/tlp_tx_arb.sv - credit-gated round-robin TLP transmit arbiter; TLP_TX_ARB_CPL_PRIO_EN gives completions absolute priority
module tlp_tx_arb
  import pcie_pkg::*;
#(
  parameter int DATA_WIDTH = PIPE_DATA_WIDTH,
  parameter int CRED_W     = TX_CRED_W,
  parameter int PH_INIT    = 32,
  parameter int NPH_INIT   = 32,
  parameter int CPLH_INIT  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_req,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_ready,
  input  logic                  wr_req,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_last,
  output logic                  wr_ready,
  input  logic                  cpl_req,
  input  logic [DATA_WIDTH-1:0] cpl_data,
  input  logic                  cpl_last,
  output logic                  cpl_ready,
  input  logic                  ph_ret,
  input  logic                  nph_ret,
  input  logic                  cplh_ret,
  output logic                  tlp_out_valid,
  output logic [DATA_WIDTH-1:0] tlp_out_data,
  output logic                  tlp_out_last,
  input  logic                  tlp_out_ready,
  output logic                  busy
);

  tx_arb_state_t r_state;
  logic [2:0]    r_grant;
  tx_req_e       r_rr_ptr;
  logic          r_first;

  logic [2:0]            w_req, w_cred_nz, w_elig, w_pick, w_consume;
  logic                  w_valid, w_last, w_xfer;
  logic [DATA_WIDTH-1:0] w_data;
  tx_req_e               w_next_ptr;
  logic [CRED_W-1:0]     w_unused_nph_cnt, w_unused_ph_cnt, w_unused_cplh_cnt;

  assign w_req  = {cpl_req, wr_req, rd_req};
  assign w_elig = w_req & w_cred_nz;

`ifdef TLP_TX_ARB_CPL_PRIO_EN
  assign w_pick = w_elig[REQ_CPL] ? 3'b100 : rr_pick({1'b0, w_elig[1:0]}, r_rr_ptr);

  // The pointer only alternates RD/WR; a completion grant leaves it where it was.
  always_comb begin
    w_next_ptr = r_rr_ptr;
    if (r_grant[REQ_RD])      w_next_ptr = REQ_WR;
    else if (r_grant[REQ_WR]) w_next_ptr = REQ_RD;
  end
`else
  assign w_pick = rr_pick(w_elig, r_rr_ptr);

  always_comb begin
    w_next_ptr = r_rr_ptr;
    if (r_grant[REQ_RD])       w_next_ptr = REQ_WR;
    else if (r_grant[REQ_WR])  w_next_ptr = REQ_CPL;
    else if (r_grant[REQ_CPL]) w_next_ptr = REQ_RD;
  end
`endif

  // Grant is all-zero in IDLE, so every output below is quiet there.
  always_comb begin
    w_valid = |(r_grant & w_req);
    w_data  = '0;
    w_last  = 1'b0;
    if (r_grant[REQ_RD]) begin
      w_data = rd_data;
      w_last = 1'b1;
    end else if (r_grant[REQ_WR]) begin
      w_data = wr_data;
      w_last = wr_last;
    end else if (r_grant[REQ_CPL]) begin
      w_data = cpl_data;
      w_last = cpl_last;
    end
  end

  assign w_xfer    = w_valid & tlp_out_ready;
  assign w_consume = r_grant & {3{w_xfer & r_first}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_grant  <= '0;
      r_rr_ptr <= REQ_RD;
      r_first  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_pick) begin
            r_grant <= w_pick;
            r_first <= 1'b1;
            r_state <= XFER;
          end
        end
        XFER: begin
          if (w_xfer) begin
            r_first <= 1'b0;
            if (w_last) begin
              r_state  <= IDLE;
              r_grant  <= '0;
              r_rr_ptr <= w_next_ptr;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  tlp_credit_cnt #(.INIT(NPH_INIT), .W(CRED_W)) u_nph_cnt (
    .clk(clk), .rst_n(rst_n), .consume(w_consume[REQ_RD]), .ret(nph_ret),
    .count(w_unused_nph_cnt), .nonzero(w_cred_nz[REQ_RD])
  );

  tlp_credit_cnt #(.INIT(PH_INIT), .W(CRED_W)) u_ph_cnt (
    .clk(clk), .rst_n(rst_n), .consume(w_consume[REQ_WR]), .ret(ph_ret),
    .count(w_unused_ph_cnt), .nonzero(w_cred_nz[REQ_WR])
  );

  tlp_credit_cnt #(.INIT(CPLH_INIT), .W(CRED_W)) u_cplh_cnt (
    .clk(clk), .rst_n(rst_n), .consume(w_consume[REQ_CPL]), .ret(cplh_ret),
    .count(w_unused_cplh_cnt), .nonzero(w_cred_nz[REQ_CPL])
  );

  assign tlp_out_valid = w_valid;
  assign tlp_out_data  = w_data;
  assign tlp_out_last  = w_last;
  assign rd_ready      = r_grant[REQ_RD] & tlp_out_ready;
  assign wr_ready      = r_grant[REQ_WR] & tlp_out_ready;
  assign cpl_ready     = r_grant[REQ_CPL] & tlp_out_ready;
  assign busy          = (r_state == XFER);

endmodule

// File: tb/tb_tlp_tx_arb.sv
// tb/tb_tlp_tx_arb.sv - directed and randomized checks of tlp_tx_arb (default and NPH_INIT=1/PH_INIT=255 instances)
module tb_tlp_tx_arb;
  import pcie_pkg::*;

  localparam int DW = 256;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic rd_req, wr_req, wr_last, cpl_req, cpl_last;
  logic ph_ret, nph_ret, cplh_ret, tlp_out_ready;
  logic [DW-1:0] rd_data, wr_data, cpl_data;

  logic rd_ready, wr_ready, cpl_ready, tlp_out_valid, tlp_out_last, busy;
  logic [DW-1:0] tlp_out_data;
  logic rd_ready2, wr_ready2, cpl_ready2, tlp_out_valid2, tlp_out_last2, busy2;
  logic [DW-1:0] tlp_out_data2;

  int checks = 0;
  int failures = 0;

  tlp_tx_arb dut (
    .clk(clk), .rst_n(rst_n),
    .rd_req(rd_req), .rd_data(rd_data), .rd_ready(rd_ready),
    .wr_req(wr_req), .wr_data(wr_data), .wr_last(wr_last), .wr_ready(wr_ready),
    .cpl_req(cpl_req), .cpl_data(cpl_data), .cpl_last(cpl_last), .cpl_ready(cpl_ready),
    .ph_ret(ph_ret), .nph_ret(nph_ret), .cplh_ret(cplh_ret),
    .tlp_out_valid(tlp_out_valid), .tlp_out_data(tlp_out_data), .tlp_out_last(tlp_out_last),
    .tlp_out_ready(tlp_out_ready), .busy(busy)
  );

  tlp_tx_arb #(.NPH_INIT(1), .PH_INIT(255)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .rd_req(rd_req), .rd_data(rd_data), .rd_ready(rd_ready2),
    .wr_req(wr_req), .wr_data(wr_data), .wr_last(wr_last), .wr_ready(wr_ready2),
    .cpl_req(cpl_req), .cpl_data(cpl_data), .cpl_last(cpl_last), .cpl_ready(cpl_ready2),
    .ph_ret(ph_ret), .nph_ret(nph_ret), .cplh_ret(cplh_ret),
    .tlp_out_valid(tlp_out_valid2), .tlp_out_data(tlp_out_data2), .tlp_out_last(tlp_out_last2),
    .tlp_out_ready(tlp_out_ready), .busy(busy2)
  );

  function automatic logic [DW-1:0] rand_beat();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic idle_inputs();
    rd_req = 0; wr_req = 0; wr_last = 0; cpl_req = 0; cpl_last = 0;
    ph_ret = 0; nph_ret = 0; cplh_ret = 0; tlp_out_ready = 0;
    rd_data = '0; wr_data = '0; cpl_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({busy, tlp_out_valid, tlp_out_last, rd_ready, wr_ready, cpl_ready} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs: got %b exp 000000",
               {busy, tlp_out_valid, tlp_out_last, rd_ready, wr_ready, cpl_ready});
    end
    checks++;
    if ({dut.u_nph_cnt.count, dut.u_ph_cnt.count, dut.u_cplh_cnt.count} !== {8'd32, 8'd32, 8'd32}) begin
      failures++;
      $display("FAIL reset_credits: got %0d/%0d/%0d exp 32/32/32",
               dut.u_nph_cnt.count, dut.u_ph_cnt.count, dut.u_cplh_cnt.count);
    end
    checks++;
    if ({dut2.u_nph_cnt.count, dut2.u_ph_cnt.count} !== {8'd1, 8'd255}) begin
      failures++;
      $display("FAIL reset_credits2: got nph=%0d ph=%0d exp 1/255",
               dut2.u_nph_cnt.count, dut2.u_ph_cnt.count);
    end
    // Asynchronous reset in the middle of a stalled write packet.
    wr_req = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_pre_busy: got %b exp 1", busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, tlp_out_valid, wr_ready} !== 3'b000) begin
      failures++;
      $display("FAIL reset_async_abort: got %b exp 000", {busy, tlp_out_valid, wr_ready});
    end
    @(negedge clk);
    wr_req = 1'b0;
    rst_n  = 1'b1;
  endtask

  task automatic test_rd_single();
    logic [DW-1:0] d;
    do_reset();
    d = rand_beat();
    tlp_out_ready = 1'b1;
    rd_req  = 1'b1;
    rd_data = d;
    #1;
    checks++;
    if ({busy, tlp_out_valid} !== 2'b00) begin
      failures++;
      $display("FAIL rd_bubble: got busy,valid=%b exp 00", {busy, tlp_out_valid});
    end
    @(negedge clk);
    #1;
    checks++;
    if ({tlp_out_valid, tlp_out_last, rd_ready, busy} !== 4'b1111) begin
      failures++;
      $display("FAIL rd_beat_ctrl: got %b exp 1111", {tlp_out_valid, tlp_out_last, rd_ready, busy});
    end
    checks++;
    if (tlp_out_data !== d) begin
      failures++;
      $display("FAIL rd_beat_data: got %h exp %h", tlp_out_data, d);
    end
    @(negedge clk);
    rd_req = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || dut.u_nph_cnt.count !== 8'd31) begin
      failures++;
      $display("FAIL rd_done: got busy=%b nph=%0d exp busy=0 nph=31", busy, dut.u_nph_cnt.count);
    end
  endtask

  // All three requesting: 1-beat reads, 2-beat writes and completions, always ready.
  task automatic test_rr_order();
    string exp_s;
    byte   got;
    int    wr_n, cpl_n;
`ifdef TLP_TX_ARB_CPL_PRIO_EN
    exp_s = "-CC-CC-CC-";
`else
    exp_s = "-R-WW-CC-R";
`endif
    do_reset();
    tlp_out_ready = 1'b1;
    rd_req = 1'b1; wr_req = 1'b1; cpl_req = 1'b1;
    wr_n = 0; cpl_n = 0;
    for (int i = 0; i < 10; i++) begin
      wr_last  = (wr_n % 2 == 1);
      cpl_last = (cpl_n % 2 == 1);
      #1;
      got = rd_ready ? "R" : wr_ready ? "W" : cpl_ready ? "C" : "-";
      if (wr_ready) wr_n++;
      if (cpl_ready) cpl_n++;
      checks++;
      if (got !== exp_s[i]) begin
        failures++;
        $display("FAIL rr_order cycle %0d: got %s exp %s", i, got, exp_s[i]);
      end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic test_wr_toggle();
    logic [DW-1:0] beats [4];
    int n;
    int held_bad;
    do_reset();
    for (int i = 0; i < 4; i++) beats[i] = rand_beat();
    n = 0;
    held_bad = 0;
    wr_req = 1'b1;
    for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
      tlp_out_ready = (cyc % 2 == 0);
      wr_data = beats[n];
      wr_last = (n == 3);
      #1;
      if (cyc > 0 && busy !== 1'b1) held_bad++;
      if (tlp_out_valid && tlp_out_ready) begin
        checks++;
        if (tlp_out_data !== beats[n] || tlp_out_last !== (n == 3)) begin
          failures++;
          $display("FAIL wr_beat %0d: got last=%b data=%h exp last=%b data=%h",
                   n, tlp_out_last, tlp_out_data, (n == 3), beats[n]);
        end
        n++;
      end
      @(negedge clk);
    end
    wr_req = 1'b0;
    tlp_out_ready = 1'b0;
    checks++;
    if (n != 4) begin
      failures++;
      $display("FAIL wr_toggle_timeout: got %0d beats exp 4", n);
    end
    checks++;
    if (held_bad != 0) begin
      failures++;
      $display("FAIL wr_grant_held: got %0d idle cycles exp 0", held_bad);
    end
    #1;
    checks++;
    if (busy !== 1'b0 || dut.u_ph_cnt.count !== 8'd31) begin
      failures++;
      $display("FAIL wr_toggle_end: got busy=%b ph=%0d exp busy=0 ph=31", busy, dut.u_ph_cnt.count);
    end
  endtask

  // dut2 holds a single non-posted credit.
  task automatic test_nph_credit();
    int found, early, wr_seen;
    do_reset();
    tlp_out_ready = 1'b1;
    rd_req  = 1'b1;
    rd_data = rand_beat();
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      #1;
      if (rd_ready2) found = 1;
      @(negedge clk);
    end
    checks++;
    if (found == 0) begin
      failures++;
      $display("FAIL nph_first_rd: got no rd transfer exp one within 10 cycles");
    end
    wr_req = 1'b1;
    wr_last = 1'b1;
    wr_data = rand_beat();
    early = 0;
    wr_seen = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (rd_ready2) early++;
      if (wr_ready2) wr_seen++;
      @(negedge clk);
    end
    checks++;
    if (early != 0 || dut2.u_nph_cnt.count !== 8'd0) begin
      failures++;
      $display("FAIL nph_blocked: got %0d rd beats nph=%0d exp 0/0", early, dut2.u_nph_cnt.count);
    end
    checks++;
    if (wr_seen == 0) begin
      failures++;
      $display("FAIL nph_wr_between: got %0d wr beats exp >0", wr_seen);
    end
    nph_ret = 1'b1;
    @(negedge clk);
    nph_ret = 1'b0;
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      #1;
      if (rd_ready2) found = 1;
      @(negedge clk);
    end
    checks++;
    if (found == 0) begin
      failures++;
      $display("FAIL nph_second_rd: got no rd transfer exp one after credit return");
    end
    idle_inputs();
  endtask

  task automatic test_ret_sat();
    do_reset();
    ph_ret = 1'b1; nph_ret = 1'b1; cplh_ret = 1'b1;
    @(negedge clk);
    ph_ret = 1'b0; nph_ret = 1'b0; cplh_ret = 1'b0;
    #1;
    checks++;
    if (dut2.u_ph_cnt.count !== 8'd255 || dut2.u_nph_cnt.count !== 8'd2) begin
      failures++;
      $display("FAIL ret_sat2: got ph=%0d nph=%0d exp 255/2", dut2.u_ph_cnt.count, dut2.u_nph_cnt.count);
    end
    checks++;
    if ({dut.u_nph_cnt.count, dut.u_ph_cnt.count, dut.u_cplh_cnt.count} !== {8'd33, 8'd33, 8'd33}) begin
      failures++;
      $display("FAIL ret_inc: got %0d/%0d/%0d exp 33/33/33",
               dut.u_nph_cnt.count, dut.u_ph_cnt.count, dut.u_cplh_cnt.count);
    end
  endtask

  task automatic test_same_cycle();
    int found;
    do_reset();
    tlp_out_ready = 1'b1;
    wr_req = 1'b1; wr_last = 1'b1; wr_data = rand_beat();
    found = 0;
    for (int i = 0; i < 6 && found == 0; i++) begin
      #1;
      if (wr_ready) begin
        ph_ret = 1'b1;
        found = 1;
      end
      @(negedge clk);
    end
    ph_ret = 1'b0;
    wr_req = 1'b0;
    #1;
    checks++;
    if (found == 0 || dut.u_ph_cnt.count !== 8'd32 || busy !== 1'b0) begin
      failures++;
      $display("FAIL same_cycle_ph: got found=%0d ph=%0d busy=%b exp 1/32/0", found, dut.u_ph_cnt.count, busy);
    end
    checks++;
    if (dut2.u_ph_cnt.count !== 8'd255) begin
      failures++;
      $display("FAIL same_cycle_ph2: got %0d exp 255", dut2.u_ph_cnt.count);
    end
  endtask

  // Transaction-level model: queued packets per requester, credit counts and a rotation pointer.
  task automatic test_random();
    beat_t q [3][$];
    int m_cred [3];
    int m_busy, m_gnt, m_first, m_ptr, pick, cyc, len;
    logic [2:0] req_v, ret_v, rdy_v, exp_rdy;
    logic exp_valid;
    beat_t b;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      m_cred[c] = 32;
      for (int p = 0; p < 15; p++) begin
        len = (c == 0) ? 1 : $urandom_range(1, 4);
        for (int i = 0; i < len; i++) begin
          b.data = rand_beat();
          b.last = (i == len - 1);
          q[c].push_back(b);
        end
      end
    end
    m_busy = 0; m_gnt = 0; m_first = 0; m_ptr = 0;
    cyc = 0;
    while (cyc < 3000 && !(q[0].size() == 0 && q[1].size() == 0 && q[2].size() == 0 && m_busy == 0)) begin
      rd_req  = (q[0].size() > 0) && ($urandom_range(0, 9) != 0);
      rd_data = (q[0].size() > 0) ? q[0][0].data : '0;
      wr_req  = (q[1].size() > 0) && ($urandom_range(0, 9) != 0);
      wr_data = (q[1].size() > 0) ? q[1][0].data : '0;
      wr_last = (q[1].size() > 0) ? q[1][0].last : 1'b0;
      cpl_req  = (q[2].size() > 0) && ($urandom_range(0, 9) != 0);
      cpl_data = (q[2].size() > 0) ? q[2][0].data : '0;
      cpl_last = (q[2].size() > 0) ? q[2][0].last : 1'b0;
      nph_ret  = ($urandom_range(0, 5) == 0);
      ph_ret   = ($urandom_range(0, 5) == 0);
      cplh_ret = ($urandom_range(0, 5) == 0);
      tlp_out_ready = ($urandom_range(0, 3) != 0);
      #1;
      req_v = {cpl_req, wr_req, rd_req};
      ret_v = {cplh_ret, ph_ret, nph_ret};
      rdy_v = {cpl_ready, wr_ready, rd_ready};
      checks++;
      if ({dut.u_nph_cnt.count, dut.u_ph_cnt.count, dut.u_cplh_cnt.count} !==
          {8'(m_cred[0]), 8'(m_cred[1]), 8'(m_cred[2])}) begin
        failures++;
        $display("FAIL rand_credits cyc %0d: got %0d/%0d/%0d exp %0d/%0d/%0d", cyc,
                 dut.u_nph_cnt.count, dut.u_ph_cnt.count, dut.u_cplh_cnt.count,
                 m_cred[0], m_cred[1], m_cred[2]);
      end
      if (m_busy == 0) begin
        checks++;
        if ({busy, tlp_out_valid, rdy_v} !== 5'b0) begin
          failures++;
          $display("FAIL rand_idle cyc %0d: got busy,valid,rdy=%b exp 00000", cyc, {busy, tlp_out_valid, rdy_v});
        end
        pick = -1;
`ifdef TLP_TX_ARB_CPL_PRIO_EN
        if (req_v[2] && m_cred[2] > 0) pick = 2;
        else
          for (int k = 0; k < 2; k++)
            if (pick < 0 && req_v[(m_ptr + k) % 2] && m_cred[(m_ptr + k) % 2] > 0) pick = (m_ptr + k) % 2;
`else
        for (int k = 0; k < 3; k++)
          if (pick < 0 && req_v[(m_ptr + k) % 3] && m_cred[(m_ptr + k) % 3] > 0) pick = (m_ptr + k) % 3;
`endif
        if (pick >= 0) begin
          m_busy = 1; m_gnt = pick; m_first = 1;
        end
      end else begin
        exp_valid = req_v[m_gnt];
        exp_rdy   = tlp_out_ready ? (3'b001 << m_gnt) : 3'b000;
        checks++;
        if ({busy, tlp_out_valid, rdy_v} !== {1'b1, exp_valid, exp_rdy}) begin
          failures++;
          $display("FAIL rand_xfer cyc %0d gnt %0d: got busy,valid,rdy=%b exp %b", cyc, m_gnt,
                   {busy, tlp_out_valid, rdy_v}, {1'b1, exp_valid, exp_rdy});
        end
        if (exp_valid) begin
          b = q[m_gnt][0];
          checks++;
          if (tlp_out_data !== b.data || tlp_out_last !== (m_gnt == 0 ? 1'b1 : b.last)) begin
            failures++;
            $display("FAIL rand_beat cyc %0d gnt %0d: got last=%b data=%h exp last=%b data=%h",
                     cyc, m_gnt, tlp_out_last, tlp_out_data, b.last, b.data);
          end
          if (tlp_out_ready) begin
            void'(q[m_gnt].pop_front());
            if (m_first != 0) m_cred[m_gnt]--;
            m_first = 0;
            if (b.last) begin
              m_busy = 0;
`ifdef TLP_TX_ARB_CPL_PRIO_EN
              if (m_gnt != 2) m_ptr = 1 - m_gnt;
`else
              m_ptr = (m_gnt + 1) % 3;
`endif
            end
          end
        end
      end
      for (int c = 0; c < 3; c++)
        if (ret_v[c] && m_cred[c] < 255) m_cred[c]++;
      cyc++;
      @(negedge clk);
    end
    idle_inputs();
    checks++;
    if (cyc >= 3000) begin
      failures++;
      $display("FAIL rand_timeout: got %0d beats left exp 0", q[0].size() + q[1].size() + q[2].size());
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_rd_single();
    test_rr_order();
    test_wr_toggle();
    test_nph_credit();
    test_ret_sat();
    test_same_cycle();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tlp_tx_arb.md
Name: tlp_tx_arb

Overview:
- Transmit-side scheduler for the transaction layer; sits between the TX TLP builders and the link layer.
- Shares the single 256-bit link-layer TLP stream among three requesters:
  - memory-read requests: non-posted, single beat;
  - memory-write requests: posted, multi-beat;
  - read completions with data: multi-beat.
- Round-robin arbitration, gated by per-class header flow-control credits.
- A grant is held for the whole packet, through its last beat.

Parameters:
- DATA_WIDTH, PCIE_PKG::PIPE_DATA_WIDTH (256), beat width.
- CRED_W, 8, width of each header-credit counter.
- PH_INIT, 32, posted-header credits after reset.
- NPH_INIT, 32, non-posted-header credits after reset.
- CPLH_INIT, 32, completion-header credits after reset.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- rd_req  in  1  read requester has a beat
- rd_data  in  DATA_WIDTH  read beat
- rd_ready  out  1  read beat consumed
- wr_req  in  1  write requester has a beat
- wr_data  in  DATA_WIDTH  write beat
- wr_last  in  1  last write beat
- wr_ready  out  1  write beat consumed
- cpl_req  in  1  completion requester has a beat
- cpl_data  in  DATA_WIDTH  completion beat
- cpl_last  in  1  last completion beat
- cpl_ready  out  1  completion beat consumed
- ph_ret  in  1  one posted-header credit returned
- nph_ret  in  1  one non-posted-header credit returned
- cplh_ret  in  1  one completion-header credit returned
- tlp_out_valid  out  1  beat valid to link layer
- tlp_out_data  out  DATA_WIDTH  beat data
- tlp_out_last  out  1  last beat of TLP
- tlp_out_ready  in  1  link layer accepts beat
- busy  out  1  a packet is granted

Behaviour:
- Clocking: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - state=IDLE, grant=none, rr pointer=RD;
  - ph/nph/cplh counters = PH_INIT/NPH_INIT/CPLH_INIT;
  - all ready outputs, tlp_out_valid, tlp_out_last, busy = 0.
- States are IDLE and XFER.
- Eligibility: requester X is eligible when X_req=1 and its class counter is nonzero (RD→nph, WR→ph, CPL→cplh).
- IDLE:
  - If any requester is eligible, register a one-hot grant to the first eligible requester at or after the rr pointer (order RD→WR→CPL→RD), then go to XFER.
  - Otherwise stay in IDLE.
  - Outputs are 0 in IDLE. Arbitration therefore costs one bubble cycle per packet.
- XFER:
  - tlp_out_valid = X_req of the granted requester.
  - tlp_out_data = X_data of the granted requester.
  - tlp_out_last = 1 for RD; X_last for WR/CPL.
  - X_ready = granted & tlp_out_ready, combinational. A beat transfers when valid & ready.
  - A granted requester dropping req mid-packet inserts gaps; the grant is held.
- Credit consume:
  - The first transferred beat of a packet decrements its class counter by 1.
  - A per-packet first-beat flag is set on grant and cleared on first transfer.
- End of packet:
  - A transfer with tlp_out_last=1 returns the block to IDLE and clears the grant.
  - It also sets the rr pointer to the requester after the granted one.
- Credit return: X_ret increments its counter.
  - Consume and return in the same cycle leave the counter unchanged.
  - Increment saturates at 2^CRED_W-1.
  - A decrement is never issued at 0, because eligibility prevents it.
- Credits are checked only at grant. Once granted, a packet completes even if the counter has since reached 0.
- busy = (state==XFER).
- Reset mid-packet aborts the packet; no partial-beat state survives.

Optional Feature:
- Macro: TLP_TX_ARB_CPL_PRIO_EN.
- Defined: in IDLE, an eligible CPL always wins over RD/WR (completions are never blocked behind requests). RD/WR still round-robin between themselves, and the rr pointer skips CPL.
- Undefined: plain three-way round-robin, as described above.

Decomposition:
- PCIE_PKG gains:
  - the requester index enum tx_req_e (REQ_RD=0, REQ_WR=1, REQ_CPL=2);
  - the state enum tx_arb_state_t (IDLE, XFER);
  - constant TX_CRED_W=8.
- One sub-module, tlp_credit_cnt (parameters INIT, W; inputs consume and ret; outputs count and nonzero), instantiated three times.

Test Plan:
- After reset, rd_req=1 with tlp_out_ready=1:
  - cycle 1: grant;
  - cycle 2: tlp_out_valid=1, tlp_out_last=1, rd_ready=1;
  - then nph=31 and state returns to IDLE.
- rd_req, wr_req and cpl_req held high, each packet 2 beats (RD 1 beat), ready=1 → grant order RD, WR, CPL, RD, with one idle cycle between packets.
- WR 4-beat packet with tlp_out_ready toggling 1,0,1,0… → data beats appear in order, grant is held, ph decrements once (to 31), wr_last passes through on beat 4.
- NPH_INIT=1: two RD packets with nph_ret pulsed 5 cycles after the first packet → second RD is granted only after the return. WR is served in between if requested.
- ph at 255 with ph_ret=1 → stays 255.
- Same-cycle WR first-beat transfer and ph_ret=1 → ph unchanged.
- With TLP_TX_ARB_CPL_PRIO_EN, all three requests held → CPL is granted on every arbitration. Without the macro → RD, WR, CPL rotation.
